// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and constants for the up/down counter
package counter_pkg;

   typedef enum logic {
      CNT_WRAP = 1'b0,
      CNT_SAT  = 1'b1
   } cnt_mode_e;

   localparam logic CNT_UP   = 1'b1;
   localparam logic CNT_DOWN = 1'b0;

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - clock-enable divider producing one tick per div+1 enabled cycles
module counter_prescaler #(
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] pre_cnt_q;
   logic [DIV_W-1:0] pre_cnt_d;

   // A pre_cnt left above a freshly lowered div fires at once rather than running round
   assign tick = en && (pre_cnt_q >= div);

   // Next prescale value: clear on load, freeze while disabled, restart after each tick
   always_comb begin
      pre_cnt_d = pre_cnt_q;
      if (clr) begin
         pre_cnt_d = '0;
      end else if (en) begin
         if (pre_cnt_q >= div) begin
            pre_cnt_d = '0;
         end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
         end
      end
   end

   // Prescale register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end

endmodule

// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - programmable-modulus up/down counter with prescaler and event flags
module updown_counter_mod
   import counter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             up_down,
   input  logic [WIDTH-1:0] max_val,
   input  logic             sat_mode,
   input  logic [DIV_W-1:0] div,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf,
   output logic             unf,
   output logic             at_max,
   output logic             at_zero
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             tick;
   logic             set_ovf, set_unf;
   cnt_mode_e        mode;

   assign mode = cnt_mode_e'(sat_mode);

   counter_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clr   (load),
      .div   (div),
      .tick  (tick)
   );

   // Load clamps into range and suppresses the step; otherwise a tick moves the count
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      set_ovf = 1'b0;
      set_unf = 1'b0;
      if (load) begin
         count_d = (load_data > max_val) ? max_val : load_data;
      end else if (tick) begin
         if (up_down == CNT_UP) begin
            if (count_q < max_val) begin
               count_d = count_q + 1'b1;
            end else begin
               count_d = (mode == CNT_SAT) ? max_val : '0;
               tc_d    = 1'b1;
               set_ovf = 1'b1;
            end
         end else begin
            if (count_q > max_val) begin
               // max_val was lowered under the count: pull back into range silently
               count_d = max_val;
            end else if (count_q != '0) begin
               count_d = count_q - 1'b1;
            end else begin
               count_d = (mode == CNT_SAT) ? '0 : max_val;
               tc_d    = 1'b1;
               set_unf = 1'b1;
            end
         end
      end
      // A new event in the clearing cycle must not be lost
      ovf_d = set_ovf | (ovf_q & ~clr_flags);
      unf_d = set_unf | (unf_q & ~clr_flags);
   end

   // Count, terminal-count pulse and sticky flags
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign count   = count_q;
   assign tc      = tc_q;
   assign ovf     = ovf_q;
   assign unf     = unf_q;
   assign at_max  = (count_q == max_val);
   assign at_zero = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// tb/tb_updown_counter_mod.sv - scoreboard bench for updown_counter_mod
module tb_updown_counter_mod;

   localparam int WIDTH = 8;
   localparam int DIV_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             en;
   logic             load;
   logic [WIDTH-1:0] load_data;
   logic             up_down;
   logic [WIDTH-1:0] max_val;
   logic             sat_mode;
   logic [DIV_W-1:0] div;
   logic             clr_flags;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             ovf;
   logic             unf;
   logic             at_max;
   logic             at_zero;

   typedef struct packed {
      logic [WIDTH-1:0] count;
      logic             tc;
      logic             ovf;
      logic             unf;
      logic             at_max;
      logic             at_zero;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   int m_count = 0;
   int m_pre   = 0;
   bit m_tc    = 0;
   bit m_ovf   = 0;
   bit m_unf   = 0;

   updown_counter_mod #(
      .WIDTH (WIDTH),
      .DIV_W (DIV_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .load      (load),
      .load_data (load_data),
      .up_down   (up_down),
      .max_val   (max_val),
      .sat_mode  (sat_mode),
      .div       (div),
      .clr_flags (clr_flags),
      .count     (count),
      .tc        (tc),
      .ovf       (ovf),
      .unf       (unf),
      .at_max    (at_max),
      .at_zero   (at_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d", tag, obs, expv);
      end
   endtask

   // Reference behaviour for one rising edge, using the inputs currently driven
   task automatic model_edge();
      bit   fire;
      bit   so;
      bit   su;
      int   mx;
      exp_t e;
      fire = 0; so = 0; su = 0;
      mx   = int'(max_val);
      if (reset) begin
         m_count = 0; m_pre = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
      end else begin
         m_tc = 0;
         if (load) begin
            m_count = (int'(load_data) > mx) ? mx : int'(load_data);
            m_pre   = 0;
         end else if (en) begin
            if (m_pre >= int'(div)) begin
               fire  = 1;
               m_pre = 0;
            end else begin
               m_pre = m_pre + 1;
            end
         end
         if (fire) begin
            if (up_down) begin
               if (m_count < mx) m_count = m_count + 1;
               else begin m_count = sat_mode ? mx : 0; m_tc = 1; so = 1; end
            end else begin
               if (m_count > mx) m_count = mx;
               else if (m_count > 0) m_count = m_count - 1;
               else begin m_count = sat_mode ? 0 : mx; m_tc = 1; su = 1; end
            end
         end
         m_ovf = so || (m_ovf && !clr_flags);
         m_unf = su || (m_unf && !clr_flags);
      end
      e.count   = WIDTH'(m_count);
      e.tc      = m_tc;
      e.ovf     = m_ovf;
      e.unf     = m_unf;
      e.at_max  = (m_count == mx);
      e.at_zero = (m_count == 0);
      sb_q.push_back(e);
   endtask

   // Push the expectation, clock the DUT, then compare away from the edge
   task automatic cyc();
      exp_t e;
      model_edge();
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check("sb_empty", 1, 0);
      end else begin
         e = sb_q.pop_front();
         check("count", count, e.count);
         check("tc", tc, e.tc);
         check("ovf", ovf, e.ovf);
         check("unf", unf, e.unf);
         check("at_max", at_max, e.at_max);
         check("at_zero", at_zero, e.at_zero);
      end
   endtask

   int seq1 [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
   int seq3 [4]  = '{1, 0, 7, 6};
   int seq3s [4] = '{1, 0, 0, 0};
   bit pat4 [6]  = '{1, 1, 0, 0, 1, 1};

   initial begin
      reset = 1; en = 0; load = 0; load_data = 0; up_down = 1;
      max_val = 0; sat_mode = 0; div = 0; clr_flags = 0;

      // Reset state with max_val==0 and with max_val==9
      cyc();
      check("rst_at_max_mv0", at_max, 1);
      max_val = 9;
      cyc();
      check("rst_count", count, 0);
      check("rst_at_zero", at_zero, 1);
      check("rst_at_max_mv9", at_max, 0);

      // Wrap up-count 0..9,0,1
      reset = 0; en = 1;
      for (int i = 0; i < 11; i++) begin
         cyc();
         check("wrap_up_seq", count, seq1[i]);
         check("wrap_up_tc", tc, (i == 9));
      end
      check("wrap_up_ovf", ovf, 1);

      // Saturate up at 5
      en = 0; clr_flags = 1;
      cyc();
      check("clr_ovf_pre", ovf, 0);
      clr_flags = 0; sat_mode = 1; max_val = 5; load = 1; load_data = 5;
      cyc();
      load = 0; en = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("sat_up_hold", count, 5);
         check("sat_up_tc", tc, 1);
      end
      check("sat_up_ovf", ovf, 1);
      en = 0; clr_flags = 1;
      cyc();
      check("clr_ovf", ovf, 0);
      clr_flags = 0;

      // Down count, wrap then saturate
      up_down = 0; sat_mode = 0; max_val = 7; load = 1; load_data = 2; en = 1;
      cyc();
      check("down_load", count, 2);
      load = 0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("down_wrap_seq", count, seq3[i]);
         check("down_wrap_tc", tc, (i == 2));
      end
      check("down_wrap_unf", unf, 1);
      sat_mode = 1; load = 1;
      cyc();
      load = 0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("down_sat_seq", count, seq3s[i]);
         check("down_sat_tc", tc, (i >= 2));
      end

      // Prescaler div=3 with en gaps, then load mid-prescale
      up_down = 1; sat_mode = 0; max_val = 9; div = 3; load = 1; load_data = 0;
      cyc();
      load = 0;
      for (int i = 0; i < 6; i++) begin
         en = pat4[i];
         cyc();
         check("pre_gap", count, (i == 5) ? 1 : 0);
      end
      en = 1;
      cyc(); cyc();
      load = 1; load_data = 0;
      cyc();
      load = 0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("pre_reload", count, (i == 3) ? 1 : 0);
      end

      // div lowered below a running pre_cnt fires on the next enabled cycle
      div = 7;
      for (int i = 0; i < 5; i++) cyc();
      div = 2;
      cyc();

      // Clamp on load and lowered max_val
      en = 0; clr_flags = 1; div = 0; load = 1; load_data = 200; max_val = 50;
      cyc();
      check("load_clamp", count, 50);
      clr_flags = 0; load = 0; max_val = 20; up_down = 0; en = 1;
      cyc();
      check("lower_max", count, 20);
      check("lower_max_tc", tc, 0);
      check("lower_max_unf", unf, 0);

      // Simultaneous cases
      reset = 1; load = 1; load_data = 5;
      cyc();
      check("reset_over_load", count, 0);
      reset = 0; up_down = 1; load_data = 3; en = 1; div = 0; max_val = 9;
      cyc();
      check("load_over_step", count, 3);
      load = 0; max_val = 3; sat_mode = 1; clr_flags = 1;
      cyc();
      check("set_over_clr", ovf, 1);
      check("set_over_clr_tc", tc, 1);
      clr_flags = 0;

      // Random mix against the model
      for (int i = 0; i < 400; i++) begin
         reset     = ($urandom_range(0, 49) == 0);
         load      = ($urandom_range(0, 15) == 0);
         en        = ($urandom_range(0, 3) != 0);
         clr_flags = ($urandom_range(0, 9) == 0);
         up_down   = $urandom_range(0, 1);
         sat_mode  = $urandom_range(0, 1);
         load_data = WIDTH'($urandom_range(0, 255));
         if ($urandom_range(0, 19) == 0) max_val = WIDTH'($urandom_range(0, 12));
         if ($urandom_range(0, 19) == 0) div = DIV_W'($urandom_range(0, 3));
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
